// File: rtl/gsm_burst_symbol_source.sv
// GSM normal-burst symbol source: byte intake, differential encoding,
// guard fill and underrun abort, one symbol per modulator strobe.
module gsm_burst_symbol_source #(
    parameter int BURST_BITS = 148,
    parameter int GUARD_BITS = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       next_symbol_strobe,
    output logic       current_symbol,
    output logic       burst_active,
    output logic       underrun
);

    localparam int CW = (BURST_BITS > 1) ? $clog2(BURST_BITS) : 1;
    localparam int GW = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BURST_BITS - 1);
    localparam logic [GW-1:0] GRD_LAST = GW'(GUARD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GUARD
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [7:0]    hold_reg;
    logic          hold_full;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_n;
    logic [GW-1:0] guard_cnt;
    logic [GW-1:0] guard_cnt_n;
    logic          prev_d;
    logic          d;
    logic          consume;
    logic          abort;

    assign in_ready     = !hold_full;
    assign burst_active = (state == BURST);

    // Next-state, next data bit and holding-register consumption per strobe
    always_comb begin
        state_n     = state;
        shift_n     = shift_reg;
        bit_idx_n   = bit_idx;
        bit_cnt_n   = bit_cnt;
        guard_cnt_n = guard_cnt;
        d           = 1'b1;
        consume     = 1'b0;
        abort       = 1'b0;
        if (next_symbol_strobe) begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift_n   = hold_reg;
                        consume   = 1'b1;
                        d         = hold_reg[7];
                        bit_cnt_n = '0;
                        bit_idx_n = '0;
                        state_n   = BURST;
                    end
                end
                BURST: begin
                    if (bit_cnt == BIT_LAST) begin
                        guard_cnt_n = '0;
                        state_n     = GUARD;
                    end else if (bit_idx == 3'd7) begin
                        if (hold_full) begin
                            shift_n   = hold_reg;
                            consume   = 1'b1;
                            d         = hold_reg[7];
                            bit_idx_n = '0;
                            bit_cnt_n = bit_cnt + 1'b1;
                        end else begin
                            abort       = 1'b1;
                            guard_cnt_n = '0;
                            state_n     = GUARD;
                        end
                    end else begin
                        shift_n   = {shift_reg[6:0], 1'b0};
                        d         = shift_reg[6];
                        bit_idx_n = bit_idx + 1'b1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GRD_LAST) begin
                        state_n = IDLE;
                    end else begin
                        guard_cnt_n = guard_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, counters, encoder and underrun pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bit_idx        <= '0;
            bit_cnt        <= '0;
            guard_cnt      <= '0;
            prev_d         <= 1'b1;
            current_symbol <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            underrun <= abort;
            if (next_symbol_strobe) begin
                state          <= state_n;
                shift_reg      <= shift_n;
                bit_idx        <= bit_idx_n;
                bit_cnt        <= bit_cnt_n;
                guard_cnt      <= guard_cnt_n;
                prev_d         <= d;
                current_symbol <= d ^ prev_d;
            end
        end
    end

    // Holding register: a new byte wins over a same-cycle move to the shifter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else begin
            if (consume) begin
                hold_full <= 1'b0;
            end
            if (in_valid && !hold_full) begin
                hold_reg  <= in_byte;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gsm_burst_symbol_source.sv
// Bench for gsm_burst_symbol_source: queue-based burst model,
// randomized byte data and input stalls.
module tb_gsm_burst_symbol_source;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       next_symbol_strobe;
    logic       current_symbol;
    logic       burst_active;
    logic       underrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] src[$];
    logic [7:0] hq[$];
    bit         bq[$];
    int         mode;
    int         sent;
    int         g;
    bit         prev;
    bit         exp_sym;
    bit         exp_act;
    bit         exp_und;

    gsm_burst_symbol_source dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .in_byte            (in_byte),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .next_symbol_strobe (next_symbol_strobe),
        .current_symbol     (current_symbol),
        .burst_active       (burst_active),
        .underrun           (underrun)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        src.delete();
        hq.delete();
        bq.delete();
        mode    = 0;
        sent    = 0;
        g       = 0;
        prev    = 1'b1;
        exp_sym = 1'b0;
        exp_act = 1'b0;
        exp_und = 1'b0;
    endtask

    task automatic load_byte();
        logic [7:0] b;
        b = hq.pop_front();
        for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
    endtask

    // mode 0: idle, 1: data bits of a burst, 2: guard fill
    task automatic model_strobe();
        bit dd;
        dd      = 1'b1;
        exp_und = 1'b0;
        case (mode)
            0: begin
                if (hq.size() > 0) begin
                    load_byte();
                    dd   = bq.pop_front();
                    sent = 1;
                    mode = 1;
                end
            end
            1: begin
                if (sent == 148) begin
                    bq.delete();
                    mode = 2;
                    g    = 0;
                end else if (bq.size() == 0) begin
                    if (hq.size() > 0) begin
                        load_byte();
                        dd   = bq.pop_front();
                        sent++;
                    end else begin
                        exp_und = 1'b1;
                        mode    = 2;
                        g       = 0;
                    end
                end else begin
                    dd = bq.pop_front();
                    sent++;
                end
            end
            default: begin
                if (g == 7) mode = 0;
                else g++;
            end
        endcase
        exp_sym = dd ^ prev;
        prev    = dd;
        exp_act = (mode == 1);
    endtask

    task automatic tick(input bit strobe, input bit allow);
        bit was_empty;
        @(negedge clock);
        next_symbol_strobe = strobe;
        in_valid = allow && (src.size() > 0);
        in_byte  = in_valid ? src[0] : 8'($urandom);
        @(posedge clock);
        was_empty = (hq.size() == 0);
        if (strobe) model_strobe();
        else exp_und = 1'b0;
        if (in_valid && was_empty) begin
            hq.push_back(in_byte);
            void'(src.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_byte = 8'h00;
        next_symbol_strobe = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({current_symbol, burst_active, underrun, in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_values: got %b expected 0001",
                     {current_symbol, burst_active, underrun, in_ready});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({current_symbol, burst_active} !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle_fill %0d: got %b expected 00",
                         i, {current_symbol, burst_active});
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 19; i++) src.push_back(8'($urandom));
        tick(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({current_symbol, burst_active, underrun} !==
                {exp_sym, exp_act, exp_und}) begin
                failures++;
                $display("FAIL pre_reset_sym %0d: got %b expected %b", i,
                         {current_symbol, burst_active, underrun},
                         {exp_sym, exp_act, exp_und});
            end
            tick(1'b0, 1'b1);
        end
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        in_valid = 1'b0;
        next_symbol_strobe = 1'b0;
        #1;
        checks++;
        if ({current_symbol, burst_active, underrun, in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL async_reset: got %b expected 0001",
                     {current_symbol, burst_active, underrun, in_ready});
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({current_symbol, burst_active, in_ready} !== 3'b001) begin
                failures++;
                $display("FAIL post_reset_fill %0d: got %b expected 001",
                         i, {current_symbol, burst_active, in_ready});
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_all_zero();
        bit syms[$];
        int act;
        int bad;
        act = 0;
        bad = 0;
        for (int i = 0; i < 19; i++) src.push_back(8'h00);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 160; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({current_symbol, burst_active, underrun} !==
                {exp_sym, exp_act, exp_und}) begin
                failures++;
                $display("FAIL all_zero_model %0d: got %b expected %b", i,
                         {current_symbol, burst_active, underrun},
                         {exp_sym, exp_act, exp_und});
            end
            syms.push_back(current_symbol);
            if (burst_active) act++;
            tick(1'b0, 1'b1);
            checks++;
            if ({current_symbol, burst_active, underrun} !==
                {exp_sym, exp_act, 1'b0}) begin
                failures++;
                $display("FAIL all_zero_hold %0d: got %b expected %b", i,
                         {current_symbol, burst_active, underrun},
                         {exp_sym, exp_act, 1'b0});
            end
        end
        for (int i = 0; i < 157; i++) begin
            if (syms[i] != ((i == 0 || i == 148) ? 1'b1 : 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL all_zero_pattern: got %0d wrong symbols expected 0", bad);
        end
        checks++;
        if (act != 148) begin
            failures++;
            $display("FAIL all_zero_active: got %0d strobes expected 148", act);
        end
    endtask

    task automatic test_diff_enc();
        logic [7:0] want;
        logic [7:0] got;
        want = 8'b0111_0111;
        got  = '0;
        src.push_back(8'hA5);
        for (int i = 0; i < 18; i++) src.push_back(8'($urandom));
        tick(1'b0, 1'b1);
        for (int i = 0; i < 165; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({current_symbol, burst_active, underrun} !==
                {exp_sym, exp_act, exp_und}) begin
                failures++;
                $display("FAIL diff_model %0d: got %b expected %b", i,
                         {current_symbol, burst_active, underrun},
                         {exp_sym, exp_act, exp_und});
            end
            if (i < 8) got[7-i] = current_symbol;
            tick(1'b0, 1'b1);
        end
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL diff_a5_symbols: got %b expected %b", got, want);
        end
    endtask

    task automatic test_underrun();
        int und;
        und = 0;
        for (int i = 0; i < 3; i++) src.push_back(8'($urandom));
        tick(1'b0, 1'b1);
        for (int i = 0; i < 195; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({current_symbol, burst_active, underrun} !==
                {exp_sym, exp_act, exp_und}) begin
                failures++;
                $display("FAIL underrun_model %0d: got %b expected %b", i,
                         {current_symbol, burst_active, underrun},
                         {exp_sym, exp_act, exp_und});
            end
            if (underrun) und++;
            if (i == 24) begin
                checks++;
                if ({underrun, burst_active} !== 2'b10) begin
                    failures++;
                    $display("FAIL underrun_edge: got %b expected 10",
                             {underrun, burst_active});
                end
                for (int k = 0; k < 19; k++) src.push_back(8'($urandom));
            end
            if (i == 33) begin
                checks++;
                if (burst_active !== 1'b1) begin
                    failures++;
                    $display("FAIL underrun_restart: got %b expected 1", burst_active);
                end
            end
            tick(1'b0, 1'b1);
            checks++;
            if (underrun !== 1'b0) begin
                failures++;
                $display("FAIL underrun_pulse_width %0d: got %b expected 0", i, underrun);
            end
        end
        checks++;
        if (und != 1) begin
            failures++;
            $display("FAIL underrun_count: got %0d expected 1", und);
        end
    endtask

    task automatic test_last_nibble();
        bit dbits[$];
        bit pd;
        logic [3:0] tail;
        pd = 1'b1;
        for (int i = 0; i < 18; i++) src.push_back(8'($urandom));
        src.push_back(8'h9F);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 160; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({current_symbol, burst_active, underrun} !==
                {exp_sym, exp_act, exp_und}) begin
                failures++;
                $display("FAIL nibble_model %0d: got %b expected %b", i,
                         {current_symbol, burst_active, underrun},
                         {exp_sym, exp_act, exp_und});
            end
            pd = current_symbol ^ pd;
            dbits.push_back(pd);
            if (i == 147 || i == 148) begin
                checks++;
                if (burst_active !== (i == 147)) begin
                    failures++;
                    $display("FAIL nibble_guard_edge %0d: got %b expected %b",
                             i, burst_active, (i == 147));
                end
            end
            tick(1'b0, 1'b1);
        end
        tail = {dbits[144], dbits[145], dbits[146], dbits[147]};
        checks++;
        if (tail !== 4'b1001) begin
            failures++;
            $display("FAIL nibble_tail: got %b expected 1001", tail);
        end
    endtask

    task automatic test_back_to_back();
        int act;
        int und;
        int busy;
        act  = 0;
        und  = 0;
        busy = 0;
        for (int i = 0; i < 38; i++) src.push_back(8'($urandom));
        tick(1'b0, 1'b1);
        for (int i = 0; i < 330; i++) begin
            tick(1'b1, ($urandom % 4) != 0);
            checks++;
            if ({current_symbol, burst_active, underrun, in_ready} !==
                {exp_sym, exp_act, exp_und, hq.size() == 0}) begin
                failures++;
                $display("FAIL b2b_model %0d: got %b expected %b", i,
                         {current_symbol, burst_active, underrun, in_ready},
                         {exp_sym, exp_act, exp_und, hq.size() == 0});
            end
            if (burst_active) act++;
            if (underrun) und++;
            if (!in_ready) busy++;
            tick(1'b0, ($urandom % 4) != 0);
            checks++;
            if (in_ready !== (hq.size() == 0)) begin
                failures++;
                $display("FAIL b2b_ready %0d: got %b expected %b",
                         i, in_ready, hq.size() == 0);
            end
        end
        checks++;
        if (und != 0 || act != 296) begin
            failures++;
            $display("FAIL b2b_counts: got und=%0d act=%0d expected und=0 act=296",
                     und, act);
        end
        checks++;
        if (busy == 0) begin
            failures++;
            $display("FAIL b2b_ready_drop: got 0 busy samples expected nonzero");
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_all_zero();
        test_diff_enc();
        test_underrun();
        test_last_nibble();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gsm_burst_symbol_source.md
# gsm_burst_symbol_source

Upstream feeder for the GMSK I/Q modulator: accepts one GSM normal burst as bytes over a valid/ready interface and differentially encodes each bit (GSM 05.04). It presents one symbol per modulator request on `next_symbol_strobe`, then appends a guard period of fill symbols. It also detects data underrun mid-burst and aborts cleanly, so the modulator never sees an undefined symbol.

## Interface
- `BURST_BITS`, 148, data bits per burst; the burst is carried in ceil(BURST_BITS/8) bytes, MSB first.
- `GUARD_BITS`, 8, fill symbols emitted after each burst or abort.

Ports (name, direction, width, meaning):
- `clock`  in  1  single system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `in_byte`  in  8  burst data byte, MSB transmitted first.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  byte holding register empty; a transfer occurs when `in_valid` and `in_ready` are both high on a rising edge.
- `next_symbol_strobe`  in  1  one-cycle request from the modulator to advance to the next symbol.
- `current_symbol`  out  1  differentially encoded symbol for the modulator.
- `burst_active`  out  1  high while a burst's data symbols are presented.
- `underrun`  out  1  one-cycle pulse when a burst is aborted for lack of data.

## Operation
- **Storage**
  - 8-bit holding register with flag `hold_full`; `in_ready = !hold_full`.
  - 8-bit shift register, `bit_idx` 0..7, `bit_cnt` 0..BURST_BITS-1, `guard_cnt` 0..GUARD_BITS-1.
- **Differential encoder**
  - Register `prev_d` (reset 1).
  - On every strobe that selects a new data bit d: `current_symbol <= d ^ prev_d` and `prev_d <= d`.
  - The fill bit is d = 1.
- **FSM states:** IDLE, BURST, GUARD. Reset state is IDLE.
  - IDLE, strobe, `hold_full`=1: move the holding register into the shift register and clear `hold_full`. Present bit 7 of the byte. Set `bit_cnt`=0, `bit_idx`=0. Go to BURST.
  - IDLE, strobe, `hold_full`=0: present fill. Stay in IDLE.
  - BURST, strobe, `bit_cnt`=BURST_BITS-1: discard the rest of the shift register, including the unused low nibble of byte 18. Present fill. Set `guard_cnt`=0. Go to GUARD.
  - BURST, strobe, `bit_idx`=7, not the last bit, `hold_full`=1: reload the shift register from the holding register and present the new MSB.
  - BURST, strobe, `bit_idx`=7, not the last bit, `hold_full`=0: pulse `underrun`. Present fill. Set `guard_cnt`=0. Go to GUARD. Bytes accepted later belong to the next burst.
  - BURST, strobe, otherwise: shift, present the next bit, and increment `bit_cnt` and `bit_idx`.
  - GUARD, strobe, `guard_cnt`=GUARD_BITS-1: present fill. Go to IDLE.
  - GUARD, strobe, otherwise: present fill and increment `guard_cnt`.
- **Holding register refill**
  - The holding register refills whenever it is empty, in any state, so the first byte of the next burst can be queued during the last byte or the guard.
  - A transfer and a holding-to-shift move in the same cycle are legal. The register ends full with the new byte.
- **`burst_active`:** high exactly while the state is BURST.

## Timing
- **Reset values:** `current_symbol`=0 (fill 1 XOR `prev_d` 1), `burst_active`=0, `underrun`=0, `in_ready`=1, state IDLE, all counters 0, `hold_full`=0.
- **Latency**
  - `current_symbol`, `burst_active` and `underrun` update on the clock edge that samples the strobe, i.e. they are valid in the next cycle.
  - The modulator latches the symbol at least 3 cycles later, so one cycle of latency is sufficient.
- **No strobe:** all outputs and state hold while `next_symbol_strobe`=0. Strobes are at least 2 cycles apart.
- **Boundary conditions**
  - Strobe and input transfer in the same cycle while the holding register is empty: the byte is not usable for that strobe. If this coincides with `bit_idx`=7 in BURST, an underrun results.
  - Back-to-back bursts: IDLE is always visited for at least one strobe between bursts.
  - Reset asserted mid-burst: all outputs go to their reset values immediately, and any queued byte is dropped.
- **Symbol counts:** one burst occupies exactly BURST_BITS strobes in BURST plus GUARD_BITS strobes in GUARD.

## Test plan
- **Reset:** assert `reset_n`=0 mid-burst → `current_symbol`=0, `burst_active`=0, `in_ready`=1 asynchronously. After release, strobes yield `current_symbol`=0 continuously.
- **All-zero burst:** 19 bytes of 0x00, bytes always available → 148 symbols, with the first symbol 1 (0 XOR 1) and the rest 0. Then 8 guard symbols: first 1, then 0. `burst_active` high for exactly 148 strobes.
- **Differential encoding:** first byte 0xA5 → data bits 1,0,1,0,0,1,0,1 → symbols 0,1,1,1,0,1,1,1.
- **Underrun:** withhold byte 3 until after the strobe at `bit_cnt`=23 → `underrun` pulses once on that edge, `burst_active` drops, 8 fill symbols follow, then IDLE.
- **Last-byte nibble:** byte 18 = 0x9F → last four data bits 1,0,0,1 are transmitted and the low nibble never appears. The GUARD transition occurs on the 148th-symbol strobe.
- **Back-to-back with stalls:** two bursts queued, `in_valid` toggled randomly with no starvation → no underrun, each burst is 148+8 symbols, and `in_ready` drops while the holding register is full.
